wb_regfile_stage: RTL and testbench

- Consumer end of the MEM/WB pipeline register. Performs writeback data selection and RV32IM load extraction (byte/half/word, sign or zero extension).
- Commits the result into a 32x32 integer register file, which provides the two ID-stage read ports.
- Also provides a registered one-cycle-late writeback forwarding record and a 64-bit retired-writeback counter.

---
 rtl/wb_regfile_stage_if.sv | 38 +++
 rtl/wb_regfile_stage.sv | 73 +++++++
 tb/tb_wb_regfile_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_stage_if.sv
// MEM/WB-to-writeback bus for wb_regfile_stage: pipeline inputs, ID read ports,
// writeback value, forwarding record and retired-writeback count.
interface wb_regfile_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 64
);
  logic                  Write_Enable;
  logic                  Memory_Access;
  logic [DATA_WIDTH-1:0] Memory_Data;
  logic [DATA_WIDTH-1:0] ALU_Output;
  logic [ADDR_WIDTH-1:0] Write_Address;
  logic [2:0]            Load_Funct3;
  logic [1:0]            Byte_Offset;
  logic [ADDR_WIDTH-1:0] Read_Address1;
  logic [ADDR_WIDTH-1:0] Read_Address2;
  logic [DATA_WIDTH-1:0] Read_Data1;
  logic [DATA_WIDTH-1:0] Read_Data2;
  logic [DATA_WIDTH-1:0] WB_Data;
  logic                  Fwd_Valid;
  logic [ADDR_WIDTH-1:0] Fwd_Address;
  logic [DATA_WIDTH-1:0] Fwd_Data;
  logic [CNT_WIDTH-1:0]  Retired_Count;

  modport master (
    output Write_Enable, Memory_Access, Memory_Data, ALU_Output, Write_Address,
           Load_Funct3, Byte_Offset, Read_Address1, Read_Address2,
    input  Read_Data1, Read_Data2, WB_Data, Fwd_Valid, Fwd_Address, Fwd_Data,
           Retired_Count
  );

  modport slave (
    input  Write_Enable, Memory_Access, Memory_Data, ALU_Output, Write_Address,
           Load_Funct3, Byte_Offset, Read_Address1, Read_Address2,
    output Read_Data1, Read_Data2, WB_Data, Fwd_Valid, Fwd_Address, Fwd_Data,
           Retired_Count
  );
endinterface

// File: rtl/wb_regfile_stage.sv
// Writeback stage: RV32 load extraction, 32x32 register file, forwarding record
// and retired counter. Define WB_BYPASS_EN for write-first read ports.
module wb_regfile_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int CNT_WIDTH  = 64
) (
  input logic              CLK,
  input logic              Reset,
  wb_regfile_stage_if.slave bus
);
  localparam int AW = $clog2(REG_COUNT);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] load_value;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  write_hit;
  logic                  fwd_valid_q;
  logic [AW-1:0]         fwd_addr_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  always_comb begin
    byte_sel = bus.Memory_Data[{bus.Byte_Offset, 3'b000} +: 8];
    half_sel = bus.Memory_Data[{bus.Byte_Offset[1], 4'b0000} +: 16];
    unique case (bus.Load_Funct3)
      3'b000:  load_value = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_value = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b001:  load_value = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b101:  load_value = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: load_value = bus.Memory_Data;
    endcase
    wb_data   = bus.Memory_Access ? load_value : bus.ALU_Output;
    write_hit = bus.Write_Enable && (bus.Write_Address != '0);
  end

  // x0 is never written, but reads still mask it so reset-free builds stay safe.
  always_comb begin
    rd1 = (bus.Read_Address1 == '0) ? '0 : regs[bus.Read_Address1];
    rd2 = (bus.Read_Address2 == '0) ? '0 : regs[bus.Read_Address2];
`ifdef WB_BYPASS_EN
    if (write_hit && bus.Read_Address1 == bus.Write_Address) rd1 = wb_data;
    if (write_hit && bus.Read_Address2 == bus.Write_Address) rd2 = wb_data;
`endif
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (write_hit) regs[bus.Write_Address] <= wb_data;
      if (bus.Write_Enable) cnt_q <= cnt_q + CNT_WIDTH'(1);
      fwd_valid_q <= write_hit;
      fwd_addr_q  <= bus.Write_Address;
      fwd_data_q  <= wb_data;
    end
  end

  assign bus.Read_Data1    = rd1;
  assign bus.Read_Data2    = rd2;
  assign bus.WB_Data       = wb_data;
  assign bus.Fwd_Valid     = fwd_valid_q;
  assign bus.Fwd_Address   = fwd_addr_q;
  assign bus.Fwd_Data      = fwd_data_q;
  assign bus.Retired_Count = cnt_q;
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: load-extraction vector table, directed
// sequences, randomized traffic against an array model, and counter wrap on a narrow instance.
module tb_wb_regfile_stage;
  localparam bit BYP =
`ifdef WB_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  wb_regfile_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(64)) ifc ();
  wb_regfile_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4))  ifw ();

  wb_regfile_stage #(.DATA_WIDTH(32), .REG_COUNT(32), .CNT_WIDTH(64)) dut (
    .CLK(CLK), .Reset(Reset), .bus(ifc.slave));
  wb_regfile_stage #(.DATA_WIDTH(32), .REG_COUNT(32), .CNT_WIDTH(4)) dut_w (
    .CLK(CLK), .Reset(Reset), .bus(ifw.slave));

  int errors = 0;
  int checks = 0;

  logic [31:0]     mref [32];
  longint unsigned cnt_ref;
  logic            fv_ref;
  logic [4:0]      fa_ref;
  logic [31:0]     fd_ref;
  logic [31:0]     wb_pending;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_wb(input logic [31:0] md, input logic [31:0] alu,
                                         input logic macc, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [31:0] v;
    if (!macc) return alu;
    case (f3)
      3'd0, 3'd4: begin
        v = (md >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (md >> (16 * off[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = md;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (BYP && !Reset && ifc.Write_Enable && ifc.Write_Address != 5'd0 && ra == ifc.Write_Address)
      return wb_pending;
    return mref[ra];
  endfunction

  // Apply inputs, then compare combinational outputs against the model.
  task automatic drive(input logic rst, input logic we, input logic macc,
                       input logic [31:0] md, input logic [31:0] alu, input logic [4:0] wa,
                       input logic [2:0] f3, input logic [1:0] off,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    Reset = rst;
    ifc.Write_Enable = we;  ifc.Memory_Access = macc; ifc.Memory_Data = md;
    ifc.ALU_Output = alu;   ifc.Write_Address = wa;   ifc.Load_Funct3 = f3;
    ifc.Byte_Offset = off;  ifc.Read_Address1 = ra1;  ifc.Read_Address2 = ra2;
    #1;
    wb_pending = ref_wb(md, alu, macc, f3, off);
    if (!rst) begin
      chk("wb_data", {32'h0, ifc.WB_Data}, {32'h0, wb_pending});
      chk("read_data1", {32'h0, ifc.Read_Data1}, {32'h0, ref_rd(ra1)});
      chk("read_data2", {32'h0, ifc.Read_Data2}, {32'h0, ref_rd(ra2)});
    end
  endtask

  // Clock edge: update the model and compare registered outputs.
  task automatic tick();
    @(posedge CLK);
    if (Reset) begin
      foreach (mref[i]) mref[i] = 32'h0;
      cnt_ref = 0; fv_ref = 1'b0; fa_ref = 5'd0; fd_ref = 32'h0;
    end else begin
      if (ifc.Write_Enable && ifc.Write_Address != 5'd0) mref[ifc.Write_Address] = wb_pending;
      if (ifc.Write_Enable) cnt_ref = cnt_ref + 1;
      fv_ref = ifc.Write_Enable && ifc.Write_Address != 5'd0;
      fa_ref = ifc.Write_Address;
      fd_ref = wb_pending;
    end
    #1;
    chk("fwd_valid", {63'h0, ifc.Fwd_Valid}, {63'h0, fv_ref});
    chk("fwd_address", {59'h0, ifc.Fwd_Address}, {59'h0, fa_ref});
    chk("fwd_data", {32'h0, ifc.Fwd_Data}, {32'h0, fd_ref});
    chk("retired_count", ifc.Retired_Count, cnt_ref);
  endtask

  typedef struct {
    logic [31:0] md;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs [14];

  initial begin
    vecs[0]  = '{32'h80FF7F01, 3'b000, 2'd1, 32'h0000007F};
    vecs[1]  = '{32'h80FF7F01, 3'b000, 2'd3, 32'hFFFFFF80};
    vecs[2]  = '{32'h80FF7F01, 3'b100, 2'd3, 32'h00000080};
    vecs[3]  = '{32'h80FF7F01, 3'b001, 2'd2, 32'hFFFF80FF};
    vecs[4]  = '{32'h80FF7F01, 3'b101, 2'd2, 32'h000080FF};
    vecs[5]  = '{32'h80FF7F01, 3'b010, 2'd2, 32'h80FF7F01};
    vecs[6]  = '{32'h80FF7F01, 3'b000, 2'd0, 32'h00000001};
    vecs[7]  = '{32'h80FF7F01, 3'b000, 2'd2, 32'hFFFFFFFF};
    vecs[8]  = '{32'h80FF7F01, 3'b100, 2'd2, 32'h000000FF};
    vecs[9]  = '{32'h80FF7F01, 3'b001, 2'd1, 32'h00007F01};
    vecs[10] = '{32'h80FF7F01, 3'b101, 2'd3, 32'h000080FF};
    vecs[11] = '{32'h80FF7F01, 3'b011, 2'd3, 32'h80FF7F01};
    vecs[12] = '{32'h80FF7F01, 3'b110, 2'd1, 32'h80FF7F01};
    vecs[13] = '{32'h12348765, 3'b111, 2'd2, 32'h12348765};

    ifw.Write_Enable = 1'b0; ifw.Memory_Access = 1'b0; ifw.Memory_Data = '0;
    ifw.ALU_Output = '0; ifw.Write_Address = '0; ifw.Load_Funct3 = '0;
    ifw.Byte_Offset = '0; ifw.Read_Address1 = '0; ifw.Read_Address2 = '0;

    // Reset held two cycles, then every address reads zero.
    drive(1, 1, 0, 32'h0, 32'hFFFF_FFFF, 5'd4, 3'd0, 2'd0, 5'd0, 5'd0); tick();
    drive(1, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0); tick();
    chk("reset_count", ifc.Retired_Count, 64'h0);
    chk("reset_fwd_valid", {63'h0, ifc.Fwd_Valid}, 64'h0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0, 2'd0, 5'(i), 5'(31 - i));
      chk("reset_read1", {32'h0, ifc.Read_Data1}, 64'h0);
      chk("reset_read2", {32'h0, ifc.Read_Data2}, 64'h0);
      tick();
    end

    // Basic ALU write then readback.
    drive(0, 1, 0, 32'h0, 32'hDEADBEEF, 5'd5, 3'd0, 2'd0, 5'd0, 5'd0); tick();
    chk("x5_fwd_valid", {63'h0, ifc.Fwd_Valid}, 64'h1);
    chk("x5_fwd_addr", {59'h0, ifc.Fwd_Address}, 64'h5);
    chk("x5_fwd_data", {32'h0, ifc.Fwd_Data}, 64'hDEADBEEF);
    chk("x5_count", ifc.Retired_Count, 64'h1);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0, 2'd0, 5'd5, 5'd0);
    chk("x5_read", {32'h0, ifc.Read_Data1}, 64'hDEADBEEF);
    tick();

    // x0 write: no state change, but retired.
    drive(0, 1, 0, 32'h0, 32'h12345678, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0); tick();
    chk("x0_fwd_valid", {63'h0, ifc.Fwd_Valid}, 64'h0);
    chk("x0_count", ifc.Retired_Count, 64'h2);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0);
    chk("x0_read", {32'h0, ifc.Read_Data1}, 64'h0);
    tick();

    // Load extraction table.
    foreach (vecs[i]) begin
      drive(0, 0, 1, vecs[i].md, 32'h5A5A5A5A, 5'd0, vecs[i].f3, vecs[i].off, 5'd0, 5'd0);
      chk("load_vec", {32'h0, ifc.WB_Data}, {32'h0, vecs[i].exp});
      tick();
    end

    // Same-cycle read of a register being written.
    drive(0, 1, 0, 32'h0, 32'h00000001, 5'd7, 3'd0, 2'd0, 5'd0, 5'd0); tick();
    drive(0, 1, 0, 32'h0, 32'hAAAA5555, 5'd7, 3'd0, 2'd0, 5'd7, 5'd0);
    chk("bypass_same_cycle", {32'h0, ifc.Read_Data1}, BYP ? 64'hAAAA5555 : 64'h1);
    tick();
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0, 2'd0, 5'd7, 5'd7);
    chk("bypass_next_cycle", {32'h0, ifc.Read_Data1}, 64'hAAAA5555);
    tick();

    // Back-to-back writes to one register: last wins.
    drive(0, 1, 0, 32'h0, 32'h11111111, 5'd9, 3'd0, 2'd0, 5'd0, 5'd0); tick();
    drive(0, 1, 0, 32'h0, 32'h22222222, 5'd9, 3'd0, 2'd0, 5'd9, 5'd0); tick();
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0, 2'd0, 5'd9, 5'd0);
    chk("last_write_wins", {32'h0, ifc.Read_Data1}, 64'h22222222);
    tick();

    // Write coincident with reset is discarded; first post-reset edge works.
    drive(1, 1, 0, 32'h0, 32'h00000055, 5'd3, 3'd0, 2'd0, 5'd0, 5'd0); tick();
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0, 2'd0, 5'd3, 5'd0);
    chk("reset_write_x3", {32'h0, ifc.Read_Data1}, 64'h0);
    chk("reset_write_count", ifc.Retired_Count, 64'h0);
    tick();
    drive(0, 1, 1, 32'hCAFE8001, 32'h0, 5'd3, 3'd1, 2'd0, 5'd0, 5'd0); tick();
    chk("post_reset_write", {32'h0, ifc.Fwd_Data}, 64'hFFFF8001);

    // Randomized traffic; small address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), $urandom, $urandom,
            5'($urandom_range(0, 7)), 3'($urandom), 2'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      tick();
    end

    // Counter wrap on a 4-bit instance: 15 writes reach all-ones, the 16th wraps.
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'd0, 2'd0, 5'd0, 5'd0);
    ifw.Write_Enable = 1'b1; ifw.Write_Address = 5'd0;
    for (int n = 0; n < 15; n++) tick();
    chk("count_all_ones", {60'h0, ifw.Retired_Count}, 64'hF);
    tick();
    chk("count_wrap", {60'h0, ifw.Retired_Count}, 64'h0);
    ifw.Write_Enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
